// File: rtl/reorder_buffer_if.sv
// Handshake bundle between the rename/writeback/commit logic and the reorder buffer.
// master = the core side that allocates, completes and accepts retirements;
// slave  = the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5
);
    logic              alloc_valid;
    logic              alloc_has_dest;
    logic [AREG_W-1:0] alloc_dr;
    logic [PREG_W-1:0] alloc_dr_p;
    logic [PREG_W-1:0] alloc_old_dr;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_rob_idx;

    logic              cmpl_valid;
    logic [IDX_W-1:0]  cmpl_rob_idx;

    logic              retire_valid;
    logic              retire_ready;
    logic              retire_has_dest;
    logic [AREG_W-1:0] retire_dr;
    logic [PREG_W-1:0] retire_dr_p;
    logic [PREG_W-1:0] retire_old_dr;

    modport master (
        output alloc_valid, alloc_has_dest, alloc_dr, alloc_dr_p, alloc_old_dr,
        input  alloc_ready, alloc_rob_idx,
        output cmpl_valid, cmpl_rob_idx,
        input  retire_valid, retire_has_dest, retire_dr, retire_dr_p, retire_old_dr,
        output retire_ready
    );

    modport slave (
        input  alloc_valid, alloc_has_dest, alloc_dr, alloc_dr_p, alloc_old_dr,
        output alloc_ready, alloc_rob_idx,
        input  cmpl_valid, cmpl_rob_idx,
        output retire_valid, retire_has_dest, retire_dr, retire_dr_p, retire_old_dr,
        input  retire_ready
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. Entries are allocated at the tail in program
// order, marked done by out-of-order writeback, and retired from the head one per
// cycle, handing the stale physical mapping back to the free pool.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    reorder_buffer_if.slave rob,
    output logic [IDX_W:0]  count,
    output logic            empty
);
    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  has_dest_q;
    logic [AREG_W-1:0] dr_q     [DEPTH];
    logic [PREG_W-1:0] dr_p_q   [DEPTH];
    logic [PREG_W-1:0] old_dr_q [DEPTH];
    logic [IDX_W-1:0]  head_q;
    logic [IDX_W-1:0]  tail_q;
    logic [IDX_W:0]    count_q;

    logic alloc_fire;
    logic retire_fire;
    logic cmpl_hit;
    logic head_live;

    assign count             = count_q;
    assign empty             = (count_q == '0);
    assign rob.alloc_ready   = (count_q != FULL_COUNT);
    assign rob.alloc_rob_idx = tail_q;

    // Head view: retire is held off while reset is asserted, and the head fields
    // read as zero whenever the head slot holds no instruction.
    always_comb begin
        head_live           = valid_q[head_q];
        rob.retire_valid    = rstn && head_live && done_q[head_q];
        rob.retire_has_dest = head_live && has_dest_q[head_q];
        rob.retire_dr       = head_live ? dr_q[head_q]     : '0;
        rob.retire_dr_p     = head_live ? dr_p_q[head_q]   : '0;
        rob.retire_old_dr   = head_live ? old_dr_q[head_q] : '0;
    end

    // Handshake qualifiers; a completion only counts when it lands on a live entry.
    always_comb begin
        alloc_fire  = rob.alloc_valid && (count_q != FULL_COUNT);
        retire_fire = rob.retire_valid && rob.retire_ready;
        cmpl_hit    = rob.cmpl_valid && valid_q[rob.cmpl_rob_idx];
    end

    // Control state: completion first, then retire and allocate so that a fresh
    // allocation always starts with done cleared.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (cmpl_hit) begin
                done_q[rob.cmpl_rob_idx] <= 1'b1;
            end
            if (retire_fire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + IDX_W'(1);
            end
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + IDX_W'(1);
            end
            case ({alloc_fire, retire_fire})
                2'b10:   count_q <= count_q + (IDX_W+1)'(1);
                2'b01:   count_q <= count_q - (IDX_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload capture at the tail; the valid bit decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_dest_q[tail_q] <= rob.alloc_has_dest;
            dr_q[tail_q]       <= rob.alloc_dr;
            dr_p_q[tail_q]     <= rob.alloc_dr_p;
            old_dr_q[tail_q]   <= rob.alloc_old_dr;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a directed vector table, hand-written
// corner sequences and a randomized phase, all compared against a queue-based
// program-order model of the buffer.
module tb_reorder_buffer;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int PREG_W = 6;
    localparam int AREG_W = 5;

    logic           clk = 1'b0;
    logic           rstn;
    logic [IDX_W:0] count;
    logic           empty;

    reorder_buffer_if #(.IDX_W(IDX_W), .PREG_W(PREG_W), .AREG_W(AREG_W)) bus ();

    reorder_buffer #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W), .AREG_W(AREG_W)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .rob(bus),
        .count(count),
        .empty(empty)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit has_dest;
        int dr;
        int dr_p;
        int old_dr;
        bit done;
    } rob_ent_t;

    typedef struct {
        bit av;
        int adr;
        int adrp;
        int aold;
        bit cv;
        int cidx;
        bit exp_ready;
        int exp_idx;
        bit exp_rv;
        int exp_old;
        int exp_count;
        bit exp_empty;
    } vec_t;

    rob_ent_t model_q[$];
    int       next_idx;
    int       tests_run;
    int       tests_failed;

    task automatic expect_eq(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Compare every visible output against the program-order model.
    task automatic checkOutput(input string tag);
        int n;
        bit exp_rv;
        n = model_q.size();
        exp_rv = rstn && (n > 0) && model_q[0].done;
        expect_eq({tag, " count"}, 32'(count), 32'(n));
        expect_eq({tag, " empty"}, 32'(empty), 32'(n == 0));
        expect_eq({tag, " alloc_ready"}, 32'(bus.alloc_ready), 32'(n < DEPTH));
        expect_eq({tag, " alloc_rob_idx"}, 32'(bus.alloc_rob_idx), 32'(next_idx));
        expect_eq({tag, " retire_valid"}, 32'(bus.retire_valid), 32'(exp_rv));
        if (exp_rv) begin
            expect_eq({tag, " retire_has_dest"}, 32'(bus.retire_has_dest), 32'(model_q[0].has_dest));
            expect_eq({tag, " retire_dr"}, 32'(bus.retire_dr), 32'(model_q[0].dr));
            expect_eq({tag, " retire_dr_p"}, 32'(bus.retire_dr_p), 32'(model_q[0].dr_p));
            expect_eq({tag, " retire_old_dr"}, 32'(bus.retire_old_dr), 32'(model_q[0].old_dr));
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_advance();
        bit       a_fire;
        bit       r_fire;
        rob_ent_t e;
        if (!rstn) begin
            model_q.delete();
            next_idx = 0;
            return;
        end
        a_fire = bus.alloc_valid && (model_q.size() < DEPTH);
        r_fire = (model_q.size() > 0) && model_q[0].done && bus.retire_ready;
        if (bus.cmpl_valid) begin
            foreach (model_q[i]) begin
                if (model_q[i].idx == int'(bus.cmpl_rob_idx)) model_q[i].done = 1'b1;
            end
        end
        if (r_fire) void'(model_q.pop_front());
        if (a_fire) begin
            e.idx      = next_idx;
            e.has_dest = bus.alloc_has_dest;
            e.dr       = int'(bus.alloc_dr);
            e.dr_p     = int'(bus.alloc_dr_p);
            e.old_dr   = int'(bus.alloc_old_dr);
            e.done     = 1'b0;
            model_q.push_back(e);
            next_idx = (next_idx + 1) % DEPTH;
        end
    endtask

    // One cycle: drive after the falling edge, check the pre-edge state, update the model.
    task automatic applyStimulus(input bit rst_n, input bit av, input bit ahd, input int adr,
                                 input int adrp, input int aold, input bit cv, input int cidx,
                                 input bit rr, input bit chk, input string tag);
        @(negedge clk);
        rstn               = rst_n;
        bus.alloc_valid    = av;
        bus.alloc_has_dest = ahd;
        bus.alloc_dr       = AREG_W'(adr);
        bus.alloc_dr_p     = PREG_W'(adrp);
        bus.alloc_old_dr   = PREG_W'(aold);
        bus.cmpl_valid     = cv;
        bus.cmpl_rob_idx   = IDX_W'(cidx);
        bus.retire_ready   = rr;
        #1;
        if (chk) checkOutput(tag);
        model_advance();
    endtask

    task automatic do_reset(input bit chk);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, chk, "reset");
    endtask

    vec_t vecs[10];
    int   dut_retires;

    initial begin
        rstn               = 1'b0;
        bus.alloc_valid    = 1'b0;
        bus.alloc_has_dest = 1'b0;
        bus.alloc_dr       = '0;
        bus.alloc_dr_p     = '0;
        bus.alloc_old_dr   = '0;
        bus.cmpl_valid     = 1'b0;
        bus.cmpl_rob_idx   = '0;
        bus.retire_ready   = 1'b0;
        tests_run          = 0;
        tests_failed       = 0;
        next_idx           = 0;

        // Reset state, including zeroed head fields.
        do_reset(1'b0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "post-reset");
        expect_eq("reset retire_dr", 32'(bus.retire_dr), 0);
        expect_eq("reset retire_dr_p", 32'(bus.retire_dr_p), 0);
        expect_eq("reset retire_old_dr", 32'(bus.retire_old_dr), 0);
        expect_eq("reset retire_has_dest", 32'(bus.retire_has_dest), 0);

        // Directed table: three allocations completed out of order, retired in order.
        //           av adr adrp aold cv cidx rdy idx rv old cnt emp
        vecs[0] = '{1, 1,  32,  1,   0, 0,   1,  0,  0, 0,  0,  1};
        vecs[1] = '{1, 2,  33,  2,   0, 0,   1,  1,  0, 0,  1,  0};
        vecs[2] = '{1, 3,  34,  3,   0, 0,   1,  2,  0, 0,  2,  0};
        vecs[3] = '{0, 0,  0,   0,   1, 1,   1,  3,  0, 0,  3,  0};
        vecs[4] = '{0, 0,  0,   0,   1, 2,   1,  3,  0, 0,  3,  0};
        vecs[5] = '{0, 0,  0,   0,   1, 0,   1,  3,  0, 0,  3,  0};
        vecs[6] = '{0, 0,  0,   0,   0, 0,   1,  3,  1, 1,  3,  0};
        vecs[7] = '{0, 0,  0,   0,   0, 0,   1,  3,  1, 2,  2,  0};
        vecs[8] = '{0, 0,  0,   0,   0, 0,   1,  3,  1, 3,  1,  0};
        vecs[9] = '{0, 0,  0,   0,   0, 0,   1,  3,  0, 0,  0,  1};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, vecs[i].av, 1, vecs[i].adr, vecs[i].adrp, vecs[i].aold,
                          vecs[i].cv, vecs[i].cidx, 1, 1, "vec");
            expect_eq($sformatf("vec%0d alloc_ready", i), 32'(bus.alloc_ready), 32'(vecs[i].exp_ready));
            expect_eq($sformatf("vec%0d alloc_rob_idx", i), 32'(bus.alloc_rob_idx), 32'(vecs[i].exp_idx));
            expect_eq($sformatf("vec%0d retire_valid", i), 32'(bus.retire_valid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv)
                expect_eq($sformatf("vec%0d retire_old_dr", i), 32'(bus.retire_old_dr), 32'(vecs[i].exp_old));
            expect_eq($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            expect_eq($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
        end

        // Full buffer: allocation blocked even when a retire fires the same cycle.
        do_reset(1'b1);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1, 1, 1, i, i + 10, i + 20, 0, 0, 1, 1, "fill");
        applyStimulus(1, 1, 1, 30, 30, 30, 1, 0, 1, 1, "full");
        expect_eq("full alloc_ready", 32'(bus.alloc_ready), 0);
        expect_eq("full count", 32'(count), 16);
        expect_eq("full alloc_rob_idx", 32'(bus.alloc_rob_idx), 0);
        applyStimulus(1, 1, 1, 31, 31, 31, 0, 0, 1, 1, "full-retire");
        expect_eq("full-retire retire_valid", 32'(bus.retire_valid), 1);
        expect_eq("full-retire alloc_ready", 32'(bus.alloc_ready), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "after-full");
        expect_eq("after-full alloc_ready", 32'(bus.alloc_ready), 1);
        expect_eq("after-full count", 32'(count), 15);
        expect_eq("after-full alloc_rob_idx", 32'(bus.alloc_rob_idx), 0);

        // Steady stream of 40: allocate, complete next cycle, retire the cycle after.
        do_reset(1'b1);
        dut_retires = 0;
        for (int i = 0; i < 42; i++) begin
            applyStimulus(1, i < 40, 1, i % 32, i % 64, (i + 7) % 64,
                          (i >= 1) && (i <= 40), (i + 15) % 16, 1, 1, "stream");
            expect_eq($sformatf("stream%0d count<=2", i), 32'(count <= 2), 1);
            if (bus.retire_valid) dut_retires++;
        end
        expect_eq("stream retire total", 32'(dut_retires), 40);

        // Stalled retire: head fields hold while retire_ready is low.
        do_reset(1'b1);
        applyStimulus(1, 1, 1, 7, 40, 12, 0, 0, 0, 1, "stall-alloc");
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, "stall-cmpl");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "stall");
            expect_eq("stall retire_valid", 32'(bus.retire_valid), 1);
            expect_eq("stall retire_dr_p", 32'(bus.retire_dr_p), 40);
            expect_eq("stall retire_old_dr", 32'(bus.retire_old_dr), 12);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "stall-release");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "stall-after");
        expect_eq("stall-after empty", 32'(empty), 1);
        expect_eq("stall-after alloc_rob_idx", 32'(bus.alloc_rob_idx), 1);

        // Store entry and a completion to an unallocated index.
        do_reset(1'b1);
        applyStimulus(1, 1, 1, 4, 41, 20, 0, 0, 0, 1, "st-a0");
        applyStimulus(1, 1, 0, 0, 42, 21, 0, 0, 0, 1, "st-a1");
        applyStimulus(1, 1, 1, 6, 43, 22, 1, 9, 0, 1, "st-a2");
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, 0, 0, 0, 0, 1, i, 0, 1, "st-cmpl");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "st-r0");
        expect_eq("st-r0 retire_has_dest", 32'(bus.retire_has_dest), 1);
        expect_eq("st-r0 retire_old_dr", 32'(bus.retire_old_dr), 20);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "st-r1");
        expect_eq("st-r1 retire_valid", 32'(bus.retire_valid), 1);
        expect_eq("st-r1 retire_has_dest", 32'(bus.retire_has_dest), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "st-r2");
        expect_eq("st-r2 retire_old_dr", 32'(bus.retire_old_dr), 22);
        for (int i = 3; i <= 9; i++)
            applyStimulus(1, 1, 1, i, i + 44, i, 0, 0, 1, 1, "st-fill");
        for (int i = 3; i <= 8; i++)
            applyStimulus(1, 0, 0, 0, 0, 0, 1, i, 1, 1, "st-cmpl2");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "st-drain");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "st-idx9");
            expect_eq("st-idx9 retire_valid", 32'(bus.retire_valid), 0);
            expect_eq("st-idx9 count", 32'(count), 1);
        end

        // Reset mid-stream with a retire-ready head.
        do_reset(1'b1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 1, 1, i + 1, i + 50, i + 1, 0, 0, 0, 1, "mid-fill");
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, "mid-cmpl");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "mid-ready");
        expect_eq("mid-ready retire_valid", 32'(bus.retire_valid), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "mid-reset");
        expect_eq("mid-reset retire_valid", 32'(bus.retire_valid), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "mid-after");
        expect_eq("mid-after count", 32'(count), 0);
        expect_eq("mid-after retire_valid", 32'(bus.retire_valid), 0);
        expect_eq("mid-after alloc_rob_idx", 32'(bus.alloc_rob_idx), 0);

        // Randomized traffic with occasional resets.
        do_reset(1'b1);
        for (int i = 0; i < 400; i++) begin
            bit rs;
            bit av;
            bit cv;
            bit rr;
            int cidx;
            rs = ($urandom_range(0, 199) != 0);
            av = ($urandom_range(0, 9) < 7);
            cv = ($urandom_range(0, 9) < 6);
            rr = ($urandom_range(0, 3) != 0);
            if ((model_q.size() > 0) && ($urandom_range(0, 3) != 0))
                cidx = model_q[$urandom_range(0, model_q.size() - 1)].idx;
            else
                cidx = $urandom_range(0, DEPTH - 1);
            applyStimulus(rs, av, $urandom_range(0, 1), $urandom_range(0, 31),
                          $urandom_range(0, 63), $urandom_range(0, 63), cv, cidx, rr, 1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
